// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_sequencer
//  Purpose  : Control and state holding for an AES-128 encryption engine. It
//             accepts a plaintext/key pair, applies the initial AddRoundKey,
//             and then iterates ten rounds through an external combinational
//             round datapath. The datapath performs SubBytes, ShiftRows,
//             MixColumns, key expansion and AddRoundKey. The ciphertext is
//             then presented with a valid/ready handshake.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             in_valid/in_ready   - input handshake (ready only in IDLE)
//             pt_in, key_in       - plaintext and key, byte 0 = [127:120]
//             rnd_state_o/key_o   - current state and round key to datapath
//             rnd_rcon_o          - Rcon for this round's key expansion
//             rnd_last_o          - final round (datapath skips MixColumns)
//             rnd_state_i/key_i   - datapath results captured each round
//             ct_out, out_valid,
//             out_ready           - output handshake
//             empty               - no block held
//             round_o             - current round (0 outside ROUND)
//             abort               - only present with AES_SEQ_ABORT_EN
//  Options  : `define AES_SEQ_ABORT_EN adds the abort input. When abort is
//             asserted in ROUND or DONE, the in-flight block is dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_round_sequencer (
   input  logic           clk,
   input  logic           rst,
`ifdef AES_SEQ_ABORT_EN
   input  logic           abort,
`endif
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [127:0]   pt_in,
   input  logic [127:0]   key_in,
   output logic [127:0]   rnd_state_o,
   output logic [127:0]   rnd_key_o,
   output logic [7:0]     rnd_rcon_o,
   output logic           rnd_last_o,
   input  logic [127:0]   rnd_state_i,
   input  logic [127:0]   rnd_key_i,
   output logic [127:0]   ct_out,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           empty,
   output logic [3:0]     round_o
);

   localparam logic [1:0] C_IDLE       = 2'd0;
   localparam logic [1:0] C_ROUND      = 2'd1;
   localparam logic [1:0] C_DONE       = 2'd2;
   localparam logic [3:0] C_LAST_ROUND = 4'd10;
   localparam logic [7:0] C_RCON_INIT  = 8'h01;

   logic [1:0]   fsm_d,   fsm_q;
   logic [127:0] blk_d,   blk_q;
   logic [127:0] key_d,   key_q;
   logic [7:0]   rcon_d,  rcon_q;
   logic [3:0]   round_d, round_q;
   logic         w_abort;

`ifdef AES_SEQ_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   // Doubling in GF(2^8); 80h wraps to 1Bh so Rcon follows 01..80,1B,36.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   always_comb begin
      fsm_d   = fsm_q;
      blk_d   = blk_q;
      key_d   = key_q;
      rcon_d  = rcon_q;
      round_d = round_q;

      case (fsm_q)
         C_IDLE: begin
            if (in_valid) begin
               fsm_d   = C_ROUND;
               blk_d   = pt_in ^ key_in;   // round-0 AddRoundKey
               key_d   = key_in;
               rcon_d  = C_RCON_INIT;
               round_d = 4'd1;
            end
         end
         C_ROUND: begin
            blk_d  = rnd_state_i;
            key_d  = rnd_key_i;
            rcon_d = xtime(rcon_q);
            if (round_q == C_LAST_ROUND) begin
               fsm_d   = C_DONE;
               round_d = 4'd0;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         C_DONE: begin
            // blk_q is held untouched, so ct_out stays stable under back-pressure
            if (out_ready) begin
               fsm_d = C_IDLE;
            end
         end
         default: begin
            fsm_d   = C_IDLE;
            round_d = 4'd0;
         end
      endcase

      // Abort discards the block and restores the reset image of every register.
      if (w_abort && (fsm_q != C_IDLE)) begin
         fsm_d   = C_IDLE;
         blk_d   = '0;
         key_d   = '0;
         rcon_d  = C_RCON_INIT;
         round_d = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q   <= C_IDLE;
         blk_q   <= '0;
         key_q   <= '0;
         rcon_q  <= C_RCON_INIT;
         round_q <= 4'd0;
      end else begin
         fsm_q   <= fsm_d;
         blk_q   <= blk_d;
         key_q   <= key_d;
         rcon_q  <= rcon_d;
         round_q <= round_d;
      end
   end

   assign in_ready    = (fsm_q == C_IDLE);
   assign empty       = (fsm_q == C_IDLE);
   assign out_valid   = (fsm_q == C_DONE);
   assign rnd_state_o = blk_q;
   assign rnd_key_o   = key_q;
   assign rnd_rcon_o  = rcon_q;
   assign rnd_last_o  = (fsm_q == C_ROUND) && (round_q == C_LAST_ROUND);
   assign ct_out      = blk_q;
   assign round_o     = (fsm_q == C_ROUND) ? round_q : 4'd0;

endmodule
`default_nettype wire

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL use a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  plaintext/key offered.
REQ-005 in_ready  output  1  high only in IDLE.
REQ-006 pt_in  input  128  plaintext; byte 0 = bits [127:120].
REQ-007 key_in  input  128  cipher key, same byte order.
REQ-008 rnd_state_o  output  128  current state to the external round datapath.
REQ-009 rnd_key_o  output  128  current round key to the datapath.
REQ-010 rnd_rcon_o  output  8  Rcon for the current round's key expansion.
REQ-011 rnd_last_o  output  1  round 10: datapath skips MixColumns.
REQ-012 rnd_state_i  input  128  combinational round result from the datapath.
REQ-013 rnd_key_i  input  128  combinational next round key from the datapath.
REQ-014 ct_out  output  128  ciphertext.
REQ-015 out_valid  output  1  ct_out valid.
REQ-016 out_ready  input  1  consumer accepts ct_out.
REQ-017 empty  output  1  high when no block is held (IDLE).
REQ-018 round_o  output  4  current round number (0 in IDLE/DONE).

Function
REQ-019 SHALL implement FSM states IDLE, ROUND, DONE; illegal encodings go to IDLE.
REQ-020 IDLE: accept on in_valid&&in_ready; load state_reg=pt_in^key_in, key_reg=key_in, rcon_reg=8'h01, round=1; go to ROUND.
REQ-021 ROUND: each cycle capture state_reg<=rnd_state_i, key_reg<=rnd_key_i, round<=round+1, rcon_reg<=xtime(rcon_reg).
REQ-022 xtime SHALL be {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00), so 80h wraps to 1Bh; sequence is 01,02,04,08,10,20,40,80,1B,36.
REQ-023 rnd_last_o SHALL be high iff state==ROUND and round==10; that capture moves the FSM to DONE.
REQ-024 rnd_state_o, rnd_key_o, and rnd_rcon_o SHALL be driven directly from state_reg, key_reg, and rcon_reg.
REQ-025 DONE: out_valid=1 and ct_out=state_reg; both SHALL hold stable while out_ready=0.
REQ-026 DONE with out_ready=1: go to IDLE next cycle; out_valid drops.
REQ-027 Latency: acceptance edge plus 10 round edges; out_valid SHALL be high in the 11th cycle after acceptance.
REQ-028 in_valid outside IDLE SHALL be ignored; no second block is accepted until the DONE handshake completes.
REQ-029 The earliest back-to-back acceptance SHALL be the cycle after the DONE handshake, giving a minimum throughput of 12 cycles per block.
REQ-030 empty SHALL equal (state==IDLE).

Reset
REQ-031 rst SHALL force IDLE regardless of state, including mid-ROUND and DONE; the in-flight block is discarded.
REQ-032 Reset values: in_ready=1, out_valid=0, empty=1, round_o=0, rnd_last_o=0, rcon_reg=01h, state_reg=key_reg=0, ct_out=0.

Configuration
REQ-033 Macro AES_SEQ_ABORT_EN SHALL add input port abort (1 bit); abort=1 in ROUND or DONE returns to IDLE on the next edge with out_valid=0 and registers at reset values.
REQ-034 Without AES_SEQ_ABORT_EN, the abort port SHALL be absent and behaviour is per REQ-019..030.
REQ-035 With AES_SEQ_ABORT_EN, rst SHALL take priority over abort, and abort in IDLE has no effect (in_valid accepted normally).

Verification (bench supplies a reference round datapath model)
REQ-036 key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a with out_valid exactly 11 cycles after acceptance.
REQ-037 key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32; rnd_rcon_o per round = 01,02,04,08,10,20,40,80,1B,36; rnd_last_o high only in round 10.
REQ-038 out_ready held 0 for 20 cycles in DONE -> ct_out/out_valid stable; in_valid=1 pulses ignored (in_ready=0); release -> IDLE, empty=1.
REQ-039 rst asserted in round 5 -> next cycle IDLE, in_ready=1, out_valid=0, round_o=0; a new block then completes correctly.
REQ-040 Two blocks in_valid held continuously -> second accepted the cycle after the first DONE handshake; both ciphertexts correct.
REQ-041 (AES_SEQ_ABORT_EN) abort in round 3 -> IDLE next cycle, no out_valid; the following block is correct.
